// File: rtl/iis_tx_ctrl.sv
// IIS transmit sequencer: primes the TX FIFO, gates the sender,
// counts words and raises done/underrun events.
module iis_tx_ctrl #(
  parameter int CNT_W       = 16,
  parameter int LEVEL_W     = 11,
  parameter int PRIME_LEVEL = 2
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic               cfg_abort,
  input  logic [CNT_W-1:0]   cfg_num,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               tx_rden,
  output logic [2:0]         send_ctrl,
  output logic               busy,
  output logic [CNT_W-1:0]   words_sent,
  output logic               irq_done,
  output logic               irq_underrun,
  output logic [7:0]         underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [7:0]         ucnt_q, ucnt_d;
  logic               stop_q, stop_d;
  logic               uirq_q, uirq_d;

  logic               abort;
  logic               start;
  logic               primed;
  logic               rd_run;
  logic               underrun;
  logic               terminal;
  logic [CNT_W-1:0]   words_inc;

  assign abort     = cfg_abort | ~cfg_en;
  assign start     = (state_q == IDLE) & cfg_start & cfg_en;
  assign primed    = fifo_level >= LEVEL_W'(PRIME_LEVEL);
  assign rd_run    = (state_q == RUN) & tx_rden & ~abort;
  assign underrun  = rd_run & (fifo_level == '0);
  assign words_inc = words_q + CNT_W'(1);
  // A stop arriving with the word's read strobe still ends on that word
  assign terminal  = rd_run &
                     (((num_q != '0) & (words_inc == num_q)) |
                      stop_q | cfg_stop);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = PRIME;
      end
      PRIME: begin
        if (abort)       state_d = IDLE;
        else if (primed) state_d = RUN;
      end
      RUN: begin
        if (abort)         state_d = IDLE;
        else if (terminal) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    send_ctrl = 3'b000;
    busy      = 1'b1;
    irq_done  = 1'b0;
    unique case (state_q)
      IDLE:    busy      = 1'b0;
      PRIME:   send_ctrl = 3'b000;
      RUN:     send_ctrl = 3'b101;
      DONE:    irq_done  = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  always_comb begin
    num_d   = num_q;
    words_d = words_q;
    ucnt_d  = ucnt_q;
    stop_d  = stop_q;
    uirq_d  = underrun;
    if (start) begin
      num_d   = cfg_num;
      words_d = '0;
      ucnt_d  = '0;
      stop_d  = 1'b0;
    end else begin
      if (rd_run) words_d = words_inc;
      if (underrun && ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
      if (state_q == RUN && cfg_stop && !abort) stop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      num_q   <= '0;
      words_q <= '0;
      ucnt_q  <= '0;
      stop_q  <= 1'b0;
      uirq_q  <= 1'b0;
    end else begin
      num_q   <= num_d;
      words_q <= words_d;
      ucnt_q  <= ucnt_d;
      stop_q  <= stop_d;
      uirq_q  <= uirq_d;
    end
  end

  assign words_sent   = words_q;
  assign irq_underrun = uirq_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: doc/iis_tx_ctrl.md
# iis_tx_ctrl

Transfer sequencer for the IIS transmit path. It sits between the APB register file and the IIS sender, on the same clock as the sender. It primes the TX FIFO, then drives the sender's `send_ctrl` enables and counts transmitted 16-bit words. It ends the transfer on a word count, on a graceful stop, or on an abort, and raises done and underrun events for the interrupt logic.

## Interface
Parameters:
- `CNT_W`, default 16: width of the word count and limit.
- `LEVEL_W`, default 11: width of the FIFO occupancy input.
- `PRIME_LEVEL`, default 2: minimum FIFO occupancy required before the sender is enabled.

Ports:
- `clk_in`  in  1: APB/IIS clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `cfg_en`  in  1: global enable, level.
- `cfg_start`  in  1: start request, one-cycle pulse.
- `cfg_stop`  in  1: graceful stop, one-cycle pulse.
- `cfg_abort`  in  1: immediate stop, one-cycle pulse.
- `cfg_num`  in  CNT_W: words to send; 0 means continuous.
- `fifo_level`  in  LEVEL_W: TX FIFO occupancy.
- `tx_rden`  in  1: sender FIFO read strobe, one per completed word.
- `send_ctrl`  out  3: to the sender. [0] = FSM enable, [1] = 0, [2] = shift enable.
- `busy`  out  1: high whenever the state is not IDLE.
- `words_sent`  out  CNT_W: words completed in the current or last transfer.
- `irq_done`  out  1: one-cycle pulse on normal completion.
- `irq_underrun`  out  1: one-cycle pulse per underrun.
- `underrun_cnt`  out  8: saturating underrun count.

## Operation
States: IDLE, PRIME, RUN, DONE. All outputs are registered or decoded from the state register.

- **IDLE**
  - `send_ctrl`=3'b000.
  - When `cfg_start` && `cfg_en`:
    - latch `cfg_num` into `num_q`;
    - clear `words_sent`, `underrun_cnt` and `stop_pend`;
    - go to PRIME.
  - `cfg_start` with `cfg_en`=0 is ignored.
- **PRIME**
  - `send_ctrl`=3'b000.
  - When `fifo_level` >= `PRIME_LEVEL`, go to RUN.
- **RUN**
  - `send_ctrl`=3'b101.
  - On each `tx_rden`, `words_sent` increments by 1 and wraps modulo 2^CNT_W.
  - `tx_rden` while `fifo_level`==0 is an underrun:
    - `irq_underrun` pulses on the next cycle;
    - `underrun_cnt` increments and saturates at 255;
    - the transfer continues.
  - A word is terminal if either condition holds:
    - `num_q`!=0 and `words_sent`+1==`num_q` at `tx_rden`;
    - `stop_pend`=1 at `tx_rden`.
  - A terminal `tx_rden` moves the FSM to DONE.
  - `cfg_stop` sets `stop_pend`. `cfg_stop` on the same cycle as a `tx_rden` makes that word terminal.
- **DONE**
  - `send_ctrl`=3'b000.
  - `irq_done` is high for exactly this cycle.
  - Go to IDLE unconditionally.
- **Abort**: `cfg_abort`=1, or `cfg_en`=0, in PRIME, RUN or DONE.
  - Go to IDLE next cycle with no `irq_done`.
  - `words_sent` holds its value.
  - Abort from DONE still lets the `irq_done` of that cycle complete.
- **Priority**: abort > terminal count/stop > underrun accounting. An underrun on the terminal word is still counted.
- `cfg_start` while `busy` is ignored. `cfg_num` changes during a transfer have no effect.
- `cfg_stop` and `cfg_abort` in IDLE are ignored.

## Timing
- Reset: state=IDLE, `send_ctrl`=0, `busy`=0, `words_sent`=0, `irq_done`=0, `irq_underrun`=0, `underrun_cnt`=0, `stop_pend`=0, `num_q`=0.
- Reset asserted mid-transfer forces IDLE asynchronously. `send_ctrl` drops to 0 immediately.
- Start to PRIME: 1 cycle after the `cfg_start` edge. PRIME to RUN: 1 cycle after the level condition is met.
- If the FIFO is already primed, `send_ctrl`[0] rises 2 cycles after `cfg_start`.
- `words_sent` updates 1 cycle after `tx_rden`.
- DONE, with `send_ctrl`=0, is entered 1 cycle after the terminal `tx_rden`. Since `tx_rden` follows word completion, no partial word is cut.
- Abort removes `send_ctrl` 1 cycle after `cfg_abort`, and may truncate a word.
- `busy` falls on the cycle IDLE is entered.

## Test plan
- **Counted transfer.** Reset, `cfg_en`=1, `fifo_level`=8, `cfg_num`=4, `cfg_start`, then 4 `tx_rden` pulses.
  - `send_ctrl`=5 from cycle 2.
  - `words_sent` steps 1..4.
  - DONE after the 4th pulse, `irq_done` high for 1 cycle, `busy`=0.
- **Priming.** `fifo_level`=0, `cfg_start`.
  - Stays in PRIME with `send_ctrl`=0.
  - Raise `fifo_level` to 2: `send_ctrl`=5 one cycle later.
- **Continuous mode with stop.** `cfg_num`=0, 10 `tx_rden` pulses, then `cfg_stop` coincident with the 11th.
  - `words_sent`=11, `irq_done` pulses once.
  - Repeat with `cfg_stop` between pulses: ends at the next `tx_rden`.
- **Underrun.** In RUN, 3 `tx_rden` with `fifo_level`=0.
  - 3 `irq_underrun` pulses, `underrun_cnt`=3.
  - 300 underruns give `underrun_cnt`=255.
- **Abort, enable drop and reset.**
  - `cfg_abort` mid-RUN after 5 words: `send_ctrl`=0 next cycle, no `irq_done`, `words_sent`=5.
  - Repeat with `cfg_en`=0: same response.
  - Repeat with `rst` low: all outputs 0.
- **Ignored start.** `cfg_start` while `busy`, with `cfg_num` changed from 4 to 9.
  - The transfer still ends at 4 words.
  - `cfg_start` with `cfg_en`=0 stays in IDLE.
